// File: rtl/lot_pkg.sv
// Shared types and default sizing for the parking-lot entry gate controller.
package lot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        DENY    = 2'd2,
        LOCKOUT = 2'd3
    } gate_state_t;

    localparam int DEF_CAPACITY     = 16;
    localparam int DEF_CNT_W        = 5;
    localparam int DEF_OPEN_TIMEOUT = 1000;
    localparam int DEF_TMR_W        = 32;

endpackage

// File: rtl/occ_counter.sv
// Saturating occupancy counter: clamps at 0 and CAPACITY, simultaneous inc/dec cancel.
module occ_counter
    import lot_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && (count != CAP)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign full = (count == CAP);

endmodule

// File: rtl/lot_gate_ctrl.sv
// Entry-gate controller: tracks occupancy and sequences the gate through
// open / deny / timeout-lockout for cars waiting at the outer sensor.
module lot_gate_ctrl
    import lot_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int TMR_W        = DEF_TMR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_waiting,
    input  logic             enter_pulse,
    input  logic             exit_pulse,
    output logic             gate_open,
    output logic             deny,
    output logic             full,
    output logic             timeout_evt,
    output logic [CNT_W-1:0] count
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);

    gate_state_t      state;
    gate_state_t      next_state;
    logic [TMR_W-1:0] timer;
    logic             timeout_hit;

    occ_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .inc   (enter_pulse),
        .dec   (exit_pulse),
        .count (count),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timeout_evt <= 1'b0;
        end else begin
            state       <= next_state;
            timeout_evt <= timeout_hit;
        end
    end

    // Timer only runs while the gate stays open, so every fresh OPEN starts from 0.
    always_ff @(posedge clk) begin
        if (reset || (state != OPEN) || (next_state != OPEN)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (car_waiting) begin
                    next_state = full ? DENY : OPEN;
                end
            end
            OPEN: begin
                // A completed entry beats a timeout landing on the same cycle.
                if (enter_pulse) begin
                    next_state = IDLE;
                end else if (timer == TMR_LAST) begin
                    next_state  = LOCKOUT;
                    timeout_hit = 1'b1;
                end
            end
            DENY: begin
                if (!car_waiting) begin
                    next_state = IDLE;
                end else if (!full) begin
                    next_state = OPEN;
                end
            end
            LOCKOUT: begin
                if (!car_waiting) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign gate_open = (state == OPEN);
    assign deny      = (state == DENY);

endmodule

// File: tb/tb_lot_gate_ctrl.sv
// Directed self-checking bench for lot_gate_ctrl with CAPACITY=3, OPEN_TIMEOUT=8.
module tb_lot_gate_ctrl;

    logic       clk;
    logic       reset;
    logic       car_waiting;
    logic       enter_pulse;
    logic       exit_pulse;
    logic       gate_open;
    logic       deny;
    logic       full;
    logic       timeout_evt;
    logic [4:0] count;

    int checks_total  = 0;
    int checks_passed = 0;

    lot_gate_ctrl #(
        .CAPACITY     (3),
        .CNT_W        (5),
        .OPEN_TIMEOUT (8),
        .TMR_W        (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .car_waiting (car_waiting),
        .enter_pulse (enter_pulse),
        .exit_pulse  (exit_pulse),
        .gate_open   (gate_open),
        .deny        (deny),
        .full        (full),
        .timeout_evt (timeout_evt),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic checkState(input string tag, input logic go, input logic dn,
                              input logic fu, input logic to, input int cnt);
        checkOutput({tag, ".gate_open"},   32'(gate_open),   32'(go));
        checkOutput({tag, ".deny"},        32'(deny),        32'(dn));
        checkOutput({tag, ".full"},        32'(full),        32'(fu));
        checkOutput({tag, ".timeout_evt"}, 32'(timeout_evt), 32'(to));
        checkOutput({tag, ".count"},       32'(count),       32'(cnt));
        checkOutput({tag, ".exclusive"},   32'(gate_open & deny), 32'd0);
    endtask

    // One clock edge with the given inputs; pulses are dropped afterwards.
    task automatic applyStimulus(input logic cw, input logic en, input logic ex);
        car_waiting = cw;
        enter_pulse = en;
        exit_pulse  = ex;
        @(posedge clk);
        #1;
        enter_pulse = 1'b0;
        exit_pulse  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        car_waiting = 1'b0;
        enter_pulse = 1'b0;
        exit_pulse  = 1'b0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkState("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // 1: waiting car opens the gate, entry closes it
        applyStimulus(1, 0, 0);
        checkState("t1_open", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0);
        checkState("t1_enter", 0, 0, 0, 0, 1);

        // 2: fill the lot, deny, then an exit lets the car in
        applyStimulus(0, 1, 0);
        checkState("t2_cnt2", 0, 0, 0, 0, 2);
        applyStimulus(0, 1, 0);
        checkState("t2_full", 0, 0, 1, 0, 3);
        applyStimulus(1, 0, 0);
        checkState("t2_deny", 0, 1, 1, 0, 3);
        applyStimulus(1, 0, 1);
        checkState("t2_exit", 0, 1, 0, 0, 2);
        applyStimulus(1, 0, 0);
        checkState("t2_reopen", 1, 0, 0, 0, 2);

        // 3: no entry for 8 cycles -> timeout, lockout until car_waiting cycles
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1, 0, 0);
            checkState($sformatf("t3_open%0d", i), 1, 0, 0, 0, 2);
        end
        applyStimulus(1, 0, 0);
        checkState("t3_timeout", 0, 0, 0, 1, 2);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 0);
            checkState($sformatf("t3_lock%0d", i), 0, 0, 0, 0, 2);
        end
        applyStimulus(0, 0, 0);
        checkState("t3_release", 0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0);
        checkState("t3_reopen", 1, 0, 0, 0, 2);

        // 4: count saturation and simultaneous pulses
        applyStimulus(0, 1, 1);
        checkState("t4_both", 0, 0, 0, 0, 2);
        applyStimulus(0, 1, 0);
        checkState("t4_to_full", 0, 0, 1, 0, 3);
        applyStimulus(0, 1, 0);
        checkState("t4_sat_hi", 0, 0, 1, 0, 3);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkState("t4_empty", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1);
        checkState("t4_sat_lo", 0, 0, 0, 0, 0);

        // 5: reset in the middle of OPEN
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(1, 0, 0);
        checkState("t5_open", 1, 0, 0, 0, 2);
        reset = 1'b1;
        applyStimulus(1, 0, 0);
        checkState("t5_reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0);
        checkState("t5_idle", 0, 0, 0, 0, 0);

        // 6: entry on the timeout cycle wins
        applyStimulus(1, 0, 0);
        checkState("t6_open", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1, 0, 0);
        end
        checkState("t6_last_open", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0);
        checkState("t6_enter", 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0);
        checkState("t6_after", 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
